// File: rtl/drain_pkg.sv
// drain_pkg: shared types and constants for the MAC array drain controller.
// The DRAIN_RELU_EN macro (see drain_fsm) is the only build option.
package drain_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    SEND,
    CLEAR
  } drain_state_e;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int N_MACS_DEF = 4;
  localparam int IDX_W      = idx_w(N_MACS_DEF);

endpackage

// File: rtl/drain_fsm.sv
// drain_fsm: snapshots all MAC accumulators once every lane is valid, streams them out, clears the array.
// Optional build macro DRAIN_RELU_EN clamps negative output words to zero.
module drain_fsm
  import drain_pkg::*;
#(
  parameter int ACC_W  = 16,
  parameter int N_MACS = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [N_MACS-1:0]       mac_valid,
  input  logic [N_MACS*ACC_W-1:0] acc_in,
  output logic [ACC_W-1:0]        dout,
  output logic                    dout_valid,
  input  logic                    dout_ready,
  output logic                    dout_last,
  output logic [N_MACS-1:0]       clear,
  output logic                    busy,
  output logic                    done
);

  localparam int IW = idx_w(N_MACS);
  localparam logic [IW-1:0] LAST = IW'(N_MACS - 1);

  drain_state_e      state_q;
  logic [N_MACS-1:0] flags_q;
  logic [IW-1:0]     idx_q;
  logic [N_MACS-1:0] seen;
  logic              cap;
  logic              is_last;
  logic [ACC_W-1:0]  word [N_MACS];

  assign seen    = flags_q | mac_valid;
  assign cap     = (state_q == WAIT) && (&seen);
  assign is_last = (idx_q == LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      flags_q <= '0;
      idx_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            flags_q <= '0;
            state_q <= WAIT;
          end
        end
        WAIT: begin
          flags_q <= seen;
          if (&seen) begin
            idx_q   <= '0;
            state_q <= SEND;
          end
        end
        SEND: begin
          if (dout_ready) begin
            if (is_last) state_q <= CLEAR;
            else idx_q <= idx_q + IW'(1);
          end
        end
        CLEAR: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Shadow word per lane; the clamp sits after the shadow so stored data is untouched.
  for (genvar i = 0; i < N_MACS; i++) begin : g_lane
    logic [ACC_W-1:0] sh_q;

    always_ff @(posedge clk) begin
      if (rst) sh_q <= '0;
      else if (cap) sh_q <= acc_in[i*ACC_W +: ACC_W];
    end

`ifdef DRAIN_RELU_EN
    assign word[i] = sh_q[ACC_W-1] ? '0 : sh_q;
`else
    assign word[i] = sh_q;
`endif
  end

  assign dout_valid = (state_q == SEND);
  assign dout_last  = dout_valid && is_last;
  assign dout       = dout_valid ? word[idx_q] : '0;
  assign clear      = {N_MACS{state_q == CLEAR}};
  assign done       = (state_q == CLEAR);
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_drain_fsm.sv
// tb_drain_fsm: randomized drain passes checked against a pass-level model.
// Builds with or without DRAIN_RELU_EN.
module tb_drain_fsm;

  localparam int W = 16;
  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [N-1:0] mac_valid;
  logic [N*W-1:0] acc_in;
  logic [W-1:0] dout;
  logic         dout_valid;
  logic         dout_ready;
  logic         dout_last;
  logic [N-1:0] clear;
  logic         busy;
  logic         done;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  drain_fsm #(.ACC_W(W), .N_MACS(N)) dut (
    .clk(clk), .rst(rst), .start(start),
    .mac_valid(mac_valid), .acc_in(acc_in),
    .dout(dout), .dout_valid(dout_valid),
    .dout_ready(dout_ready), .dout_last(dout_last),
    .clear(clear), .busy(busy), .done(done)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] expw(input logic [N*W-1:0] a,
                                        input int k);
    logic [W-1:0] w;
    w = a[k*W +: W];
`ifdef DRAIN_RELU_EN
    if (w[W-1]) w = '0;
`endif
    return w;
  endfunction

  function automatic logic [N*W-1:0] rnd_acc();
    return {$urandom, $urandom};
  endfunction

  task automatic chk_quiet(input string tag);
    chk({tag, "_valid"}, 32'(dout_valid), 32'd0);
    chk({tag, "_last"},  32'(dout_last),  32'd0);
    chk({tag, "_clear"}, 32'(clear),      32'd0);
    chk({tag, "_busy"},  32'(busy),       32'd0);
    chk({tag, "_done"},  32'(done),       32'd0);
  endtask

  // vm: 0 all valid at once, 1 staggered one-hot, 2 random
  // rm: 0 ready high, 1 pattern 1,0,0,1,1,0,1, 2 random
  task automatic run_pass(input logic [N*W-1:0] acc,
                          input int vm, input int rm,
                          input int abort_at);
    logic [N-1:0]   seen;
    logic [N-1:0]   mv;
    logic [N*W-1:0] cap;
    logic [6:0]     pat;
    int k, cyc, rc;
    pat = 7'b1011001;
    acc_in = acc;
    mac_valid = N'($urandom);
    dout_ready = 1'($urandom);
    start = 1'b1;
    step;
    start = 1'b0;
    chk("wait_busy", 32'(busy), 32'd1);
    chk("wait_nvalid", 32'(dout_valid), 32'd0);
    seen = '0;
    cap = '0;
    cyc = 0;
    forever begin
      case (vm)
        0: mv = '1;
        1: mv = N'(1) << (cyc % N);
        default: mv = (cyc >= 8) ? '1 : (N'($urandom) & N'($urandom));
      endcase
      if (vm == 2) acc_in = rnd_acc();
      mac_valid = mv;
      start = 1'($urandom);
      dout_ready = 1'($urandom);
      cap = acc_in;
      step;
      cyc++;
      if ((seen | mv) == '1) break;
      seen |= mv;
      chk("wait_hold", 32'(dout_valid), 32'd0);
      chk("wait_busy2", 32'(busy), 32'd1);
    end
    k = 0;
    rc = 0;
    while (k < N) begin
      if (k == abort_at) begin
        start = 1'b0;
        rst = 1'b1;
        step;
        rst = 1'b0;
        chk_quiet("rst");
        chk("rst_dout", 32'(dout), 32'd0);
        step;
        chk_quiet("rst2");
        return;
      end
      chk("send_valid", 32'(dout_valid), 32'd1);
      chk("send_dout", 32'(dout), 32'(expw(cap, k)));
      chk("send_last", 32'(dout_last), 32'(k == N - 1));
      chk("send_busy", 32'(busy), 32'd1);
      chk("send_clear", 32'(clear), 32'd0);
      chk("send_done", 32'(done), 32'd0);
      acc_in = rnd_acc();
      mac_valid = N'($urandom);
      start = 1'($urandom);
      case (rm)
        0: dout_ready = 1'b1;
        1: dout_ready = pat[rc % 7];
        default: dout_ready = 1'($urandom);
      endcase
      step;
      rc++;
      if (dout_ready) k++;
    end
    start = 1'($urandom);
    dout_ready = 1'($urandom);
    chk("clr_clear", 32'(clear), 32'hF);
    chk("clr_done", 32'(done), 32'd1);
    chk("clr_busy", 32'(busy), 32'd1);
    chk("clr_nvalid", 32'(dout_valid), 32'd0);
    step;
    start = 1'b0;
    chk_quiet("idle");
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    mac_valid = '0;
    acc_in = '0;
    dout_ready = 1'b0;
    step;
    step;
    rst = 1'b0;
    chk_quiet("reset");
    chk("reset_dout", 32'(dout), 32'd0);

    run_pass({16'd50, 16'd40, 16'd30, 16'd20}, 0, 0, -1);
    run_pass({16'd50, 16'd40, 16'd30, 16'd20}, 1, 2, -1);
    run_pass(rnd_acc(), 0, 1, -1);
    run_pass(rnd_acc(), 2, 0, 2);
    run_pass({16'd50, 16'd40, 16'd30, 16'd20}, 0, 0, -1);
    run_pass({16'hFF80, 16'd0, 16'd30, 16'hFFF9}, 0, 0, -1);
    repeat (30) begin
      run_pass(rnd_acc(), $urandom_range(0, 2),
               $urandom_range(0, 2), -1);
    end
    run_pass(rnd_acc(), 2, 2, $urandom_range(0, N - 1));
    run_pass(rnd_acc(), 1, 1, -1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
